// File: rtl/aes_key_expand.sv
// AES-128 key schedule: one round key per handshake, rk0..rk10 per cipher key.
// Optional replay buffer of emitted round keys under AES_KEYEXP_REPLAY_EN.
module sbox #(
  parameter int NUM = 4
) (
  input  logic [8*NUM-1:0] din,
  output logic [8*NUM-1:0] dout
);

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse as a^254 = a^2 * a^4 * ... * a^128; zero maps to zero.
  function automatic logic [7:0] sub(input logic [7:0] a);
    logic [7:0] s;
    logic [7:0] r;
    s = a;
    r = 8'h01;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]}
             ^ {r[4:0], r[7:5]} ^ {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  always_comb begin
    dout = '0;
    for (int i = 0; i < NUM; i++)
      dout[8*i +: 8] = sub(din[8*i +: 8]);
  end

endmodule

module aes_key_expand #(
  parameter int RK_NUM = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] key_in,
  input  logic         key_valid,
  output logic         key_ready,
  output logic [127:0] rk_out,
  output logic [3:0]   rk_idx,
  output logic         rk_valid,
  input  logic         rk_ready,
  output logic         done
`ifdef AES_KEYEXP_REPLAY_EN
  ,
  input  logic [3:0]   rk_rd_idx,
  output logic [127:0] rk_rd_data
`endif
);

  typedef enum logic {IDLE, EMIT} state_t;

  localparam logic [3:0] LAST = 4'(RK_NUM - 1);

  state_t       state;
  logic [127:0] w;
  logic [3:0]   idx;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [7:0]   rc;
  logic         hs;

  assign w0 = w[127:96];
  assign w1 = w[95:64];
  assign w2 = w[63:32];
  assign w3 = w[31:0];

  assign rot = {w3[23:0], w3[31:24]};

  sbox #(.NUM(4)) u_sbox (
    .din  (rot),
    .dout (sub)
  );

  // Rcon for the round being produced, i.e. idx+1.
  always_comb begin
    rc = 8'h00;
    unique case (idx)
      4'd0:    rc = 8'h01;
      4'd1:    rc = 8'h02;
      4'd2:    rc = 8'h04;
      4'd3:    rc = 8'h08;
      4'd4:    rc = 8'h10;
      4'd5:    rc = 8'h20;
      4'd6:    rc = 8'h40;
      4'd7:    rc = 8'h80;
      4'd8:    rc = 8'h1b;
      4'd9:    rc = 8'h36;
      default: rc = 8'h00;
    endcase
  end

  assign t  = sub ^ {rc, 24'h0};
  assign n0 = w0 ^ t;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign key_ready = (state == IDLE);
  assign rk_valid  = (state == EMIT);
  assign rk_out    = w;
  assign rk_idx    = idx;
  assign hs        = rk_valid & rk_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      w     <= '0;
      idx   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (key_valid) begin
            w     <= key_in;
            idx   <= '0;
            state <= EMIT;
          end
        end
        EMIT: begin
          if (rk_ready) begin
            if (idx == LAST) begin
              state <= IDLE;
              done  <= 1'b1;
            end else begin
              w   <= {n0, n1, n2, n3};
              idx <= idx + 4'd1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef AES_KEYEXP_REPLAY_EN
  logic [127:0] rk_mem [RK_NUM];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RK_NUM; i++)
        rk_mem[i] <= '0;
    end else if (hs) begin
      rk_mem[idx] <= w;
    end
  end

  always_comb begin
    rk_rd_data = '0;
    if (rk_rd_idx <= LAST)
      rk_rd_data = rk_mem[rk_rd_idx];
  end
`endif

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: FIPS-197 vectors, backpressure, reset, random keys.
// Reference key schedule is built from a brute-force GF(2^8) S-box model.
module tb_aes_key_expand;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] rk_out;
  logic [3:0]   rk_idx;
  logic         rk_valid;
  logic         rk_ready;
  logic         done;
`ifdef AES_KEYEXP_REPLAY_EN
  logic [3:0]   rk_rd_idx;
  logic [127:0] rk_rd_data;
`endif

  aes_key_expand #(.RK_NUM(11)) dut (
    .clk        (clk),
    .rst        (rst),
    .key_in     (key_in),
    .key_valid  (key_valid),
    .key_ready  (key_ready),
    .rk_out     (rk_out),
    .rk_idx     (rk_idx),
    .rk_valid   (rk_valid),
    .rk_ready   (rk_ready),
    .done       (done)
`ifdef AES_KEYEXP_REPLAY_EN
    ,
    .rk_rd_idx  (rk_rd_idx),
    .rk_rd_data (rk_rd_data)
`endif
  );

  always #5 clk = ~clk;

  localparam logic [127:0] FIPS_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] FIPS_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] FIPS_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] ZERO_RK1  = 128'h62636363626363636263636362636363;

  int           errors = 0;
  int           checks = 0;
  logic [7:0]   sb [256];
  logic [127:0] exp_rk [11];
  logic [127:0] got_rk [11];
  int           last_cycles;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] pmul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int k = 14; k >= 8; k--)
      if (p[k]) p = p ^ (15'h11b << (k - 8));
    return p[7:0];
  endfunction

  task automatic build_sbox;
    logic [7:0] inv;
    logic [7:0] s;
    logic [7:0] c;
    c = 8'h63;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      if (x != 0)
        for (int y = 1; y < 256; y++)
          if (pmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      for (int i = 0; i < 8; i++)
        s[i] = inv[i] ^ inv[(i+4)%8] ^ inv[(i+5)%8]
             ^ inv[(i+6)%8] ^ inv[(i+7)%8] ^ c[i];
      sb[x] = s;
    end
  endtask

  task automatic expand_model(input logic [127:0] key);
    logic [31:0] wm [44];
    logic [31:0] tmp;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++)
      wm[i] = key[127 - 32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = wm[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]};
        tmp = tmp ^ {rc, 24'h0};
        rc  = pmul(rc, 8'h02);
      end
      wm[i] = wm[i-4] ^ tmp;
    end
    for (int r = 0; r < 11; r++)
      exp_rk[r] = {wm[4*r], wm[4*r+1], wm[4*r+2], wm[4*r+3]};
  endtask

  // Entered with the DUT idle; returns at the sample point of the done cycle
  // (or right after reset when abort_at hits).
  task automatic run_key(
    input logic [127:0] key,
    input int           stall_at,
    input int           stall_len,
    input bit           rnd,
    input int           abort_at,
    input bit           hold_next,
    input logic [127:0] next_key
  );
    int r;
    int cyc;
    int stalled;
    bit ready;
    expand_model(key);
    key_in    = key;
    key_valid = 1'b1;
    step;
    checks++;
    if (rk_valid !== 1'b1 || key_ready !== 1'b0) begin
      errors++;
      $display("FAIL accept: rk_valid=%b key_ready=%b want 1/0", rk_valid, key_ready);
    end
    if (hold_next) key_in = next_key;
    else key_valid = 1'b0;
    r = 0;
    cyc = 0;
    stalled = 0;
    while (r < 11 && cyc < 300) begin
      cyc++;
      checks++;
      if (rk_valid !== 1'b1 || rk_idx !== 4'(r) || rk_out !== exp_rk[r] || done !== 1'b0) begin
        errors++;
        $display("FAIL emit r=%0d: valid=%b idx=%0d rk=%h done=%b want 1/%0d/%h/0",
                 r, rk_valid, rk_idx, rk_out, done, r, exp_rk[r]);
      end
      got_rk[r] = rk_out;
      if (r == abort_at) begin
        key_valid = 1'b0;
        rst = 1'b1;
        step;
        rst = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1 || done !== 1'b0 ||
            rk_idx !== 4'd0 || rk_out !== 128'h0) begin
          errors++;
          $display("FAIL abort: valid=%b kr=%b done=%b idx=%0d rk=%h want 0/1/0/0/0",
                   rk_valid, key_ready, done, rk_idx, rk_out);
        end
        last_cycles = cyc;
        return;
      end
      ready = 1'b1;
      if (r == stall_at && stalled < stall_len) begin
        ready = 1'b0;
        stalled++;
      end else if (rnd) begin
        ready = ($urandom_range(0, 3) != 0);
      end
      rk_ready = ready;
      step;
      if (ready) r++;
    end
    rk_ready = 1'b1;
    last_cycles = cyc;
    checks++;
    if (r < 11) begin
      errors++;
      $display("FAIL timeout: reached r=%0d want 11", r);
    end
    checks++;
    if (done !== 1'b1 || key_ready !== 1'b1 || rk_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: done=%b kr=%b valid=%b want 1/1/0", done, key_ready, rk_valid);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    key_valid = 1'b0;
    key_in = '0;
    rk_ready = 1'b1;
`ifdef AES_KEYEXP_REPLAY_EN
    rk_rd_idx = '0;
`endif
    step;
    step;
    rst = 1'b0;
    checks++;
    if (key_ready !== 1'b1 || rk_valid !== 1'b0 || done !== 1'b0 ||
        rk_out !== 128'h0 || rk_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset: kr=%b valid=%b done=%b rk=%h idx=%0d want 1/0/0/0/0",
               key_ready, rk_valid, done, rk_out, rk_idx);
    end
  endtask

  task automatic test_fips;
    run_key(FIPS_KEY, -1, 0, 1'b0, -1, 1'b0, '0);
    checks++;
    if (got_rk[0] !== FIPS_KEY || got_rk[1] !== FIPS_RK1 || got_rk[10] !== FIPS_RK10) begin
      errors++;
      $display("FAIL fips: rk0=%h rk1=%h rk10=%h", got_rk[0], got_rk[1], got_rk[10]);
    end
    step;
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: done=%b want 0", done);
    end
  endtask

  task automatic test_zero_key;
    run_key('0, -1, 0, 1'b0, -1, 1'b0, '0);
    checks++;
    if (got_rk[1] !== ZERO_RK1 || last_cycles != 11) begin
      errors++;
      $display("FAIL zero_key: rk1=%h cycles=%0d want %h 11", got_rk[1], last_cycles, ZERO_RK1);
    end
    step;
  endtask

  task automatic test_backpressure;
    run_key(FIPS_KEY, 3, 5, 1'b0, -1, 1'b0, '0);
    checks++;
    if (got_rk[10] !== FIPS_RK10 || last_cycles != 16) begin
      errors++;
      $display("FAIL backpressure: rk10=%h cycles=%0d want %h 16", got_rk[10], last_cycles, FIPS_RK10);
    end
    step;
  endtask

  task automatic test_reset_mid;
    run_key(FIPS_KEY, -1, 0, 1'b0, 5, 1'b0, '0);
    run_key({$urandom, $urandom, $urandom, $urandom}, -1, 0, 1'b0, -1, 1'b0, '0);
    step;
  endtask

  task automatic test_back_to_back;
    logic [127:0] ka;
    logic [127:0] kb;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = {$urandom, $urandom, $urandom, $urandom};
    run_key(ka, 2, 2, 1'b0, -1, 1'b1, kb);
    run_key(kb, -1, 0, 1'b0, -1, 1'b0, '0);
    step;
  endtask

  task automatic test_random;
    for (int k = 0; k < 4; k++) begin
      run_key({$urandom, $urandom, $urandom, $urandom}, -1, 0, 1'b1, -1, 1'b0, '0);
      step;
    end
  endtask

`ifdef AES_KEYEXP_REPLAY_EN
  task automatic test_replay;
    run_key(FIPS_KEY, -1, 0, 1'b0, -1, 1'b0, '0);
    step;
    rk_rd_idx = 4'd10;
    #1;
    checks++;
    if (rk_rd_data !== FIPS_RK10) begin
      errors++;
      $display("FAIL replay10: got %h want %h", rk_rd_data, FIPS_RK10);
    end
    rk_rd_idx = 4'd0;
    #1;
    checks++;
    if (rk_rd_data !== FIPS_KEY) begin
      errors++;
      $display("FAIL replay0: got %h want %h", rk_rd_data, FIPS_KEY);
    end
    rk_rd_idx = 4'd12;
    #1;
    checks++;
    if (rk_rd_data !== 128'h0) begin
      errors++;
      $display("FAIL replay12: got %h want 0", rk_rd_data);
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    key_valid = 1'b0;
    key_in = '0;
    rk_ready = 1'b1;
    build_sbox;
    test_reset;
    test_fips;
    test_zero_key;
    test_backpressure;
    test_reset_mid;
    test_back_to_back;
    test_random;
`ifdef AES_KEYEXP_REPLAY_EN
    test_replay;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_key_expand.md
AES_KEY_EXPAND -- requirements
Module: aes_key_expand

Interface
REQ-001 SHALL have parameter RK_NUM, default 11, number of round keys emitted per key; AES-128 only, other values illegal.
REQ-002 SHALL have clk  input  1  sole clock; all logic rising-edge.
REQ-003 SHALL have rst  input  1  reset: one clock; reset is synchronous and active-high.
REQ-004 SHALL have key_in  input  128  cipher key; byte 0 = key_in[127:120], word w0 = key_in[127:96].
REQ-005 SHALL have key_valid  input  1  key_in valid.
REQ-006 SHALL have key_ready  output  1  block accepts a key.
REQ-007 SHALL have rk_out  output  128  current round key; same byte order as key_in.
REQ-008 SHALL have rk_idx  output  4  round number of rk_out, 0..10.
REQ-009 SHALL have rk_valid  output  1  rk_out/rk_idx valid.
REQ-010 SHALL have rk_ready  input  1  consumer accepts rk_out.
REQ-011 SHALL have done  output  1  one-cycle pulse after round key 10 is accepted.

Function
REQ-012 SHALL implement FSM with two states: IDLE (key_ready=1, rk_valid=0) and EMIT (key_ready=0, rk_valid=1).
REQ-013 SHALL, in IDLE, on key_valid&key_ready, load key_in into state register W, set idx=0, go to EMIT next cycle; key_valid ignored in EMIT.
REQ-014 SHALL drive rk_out=W and rk_idx=idx while in EMIT; first rk_valid one cycle after key handshake, rk_out equal to key_in.
REQ-015 SHALL hold rk_out and rk_idx stable while rk_valid=1 and rk_ready=0.
REQ-016 SHALL, on rk_valid&rk_ready with idx<10, load W with next round key and idx+1 on the next edge, staying in EMIT (one key per cycle with rk_ready held high).
REQ-017 SHALL compute next key combinationally: t = SubWord(RotWord(w3)) ^ {Rcon[idx+1],24'h0}; w0'=w0^t, w1'=w1^w0', w2'=w2^w1', w3'=w3^w2'.
REQ-018 SHALL define RotWord(w3) = {w3[23:0], w3[31:24]} and SubWord via the team's sbox module instantiated with NUM=4.
REQ-019 SHALL use Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36 (hex), indexed by idx+1 from a 4-bit counter; no wrap past 10.
REQ-020 SHALL, on rk_valid&rk_ready with idx==10, return to IDLE and assert done for exactly that next cycle; key_ready=1 in the same cycle.
REQ-021 SHALL accept a new key in the cycle done is high; total 12 cycles per key minimum (1 accept + 11 emit).
REQ-022 SHALL contain no combinational path from key_valid or rk_ready to any output.

Reset
REQ-023 SHALL, while rst=1 at a clock edge, set state=IDLE, W=0, idx=0, rk_valid=0, done=0, key_ready=1 (rk_out=0, rk_idx=0).
REQ-024 SHALL abort any in-progress expansion on rst with no done pulse; rst has priority over all handshakes in the same cycle.

Configuration
REQ-025 SHALL, when macro AES_KEYEXP_REPLAY_EN is defined, store each emitted round key into an 11x128 register array at index rk_idx on its handshake, and add ports rk_rd_idx input 4 and rk_rd_data output 128 (combinational read; 0 for rk_rd_idx>10).
REQ-026 SHALL clear the replay array on rst; entries from a previous key remain readable until overwritten.
REQ-027 SHALL, when AES_KEYEXP_REPLAY_EN is undefined, omit the array and both ports; all other behaviour identical.

Verification
REQ-028 SHALL cover FIPS-197: key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1 -> rk0=key, rk1=a0fafe1788542cb123a339392a6c7605, rk10=d014f9a8c9ee2589e13f0cc8b6630ca6, done one cycle after rk10 handshake.
REQ-029 SHALL cover zero key: key 0 -> rk1=62636363626363636263636362636363, rk_idx 0..10 in consecutive cycles.
REQ-030 SHALL cover backpressure: rk_ready low 5 cycles at idx=3 -> rk_out and rk_idx stable, sequence still matches REQ-028 values.
REQ-031 SHALL cover reset mid-run: rst at idx=5 -> next cycle rk_valid=0, key_ready=1, done=0; fresh key then expands correctly from rk0.
REQ-032 SHALL cover back-to-back keys: second key_valid asserted during EMIT is ignored, accepted in done cycle; rk0 of second key appears next cycle.
REQ-033 SHALL cover replay (AES_KEYEXP_REPLAY_EN): after REQ-028 run, rk_rd_idx=10 -> rk_rd_data=d014f9a8c9ee2589e13f0cc8b6630ca6; rk_rd_idx=12 -> 0.
